// File: rtl/usb_tx.sv
// rtl/usb_tx.sv - USB LS/FS line transmitter: SYNC, stuffed NRZI data, EOP; optional abort under USB_TX_ABORT_EN
module usb_tx (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
`ifdef USB_TX_ABORT_EN
  input  logic       tx_abort,
`endif
  output logic       tx_ready,
  output logic       d_o,
  output logic       se0,
  output logic       oe,
  output logic       busy
);

`ifdef USB_TX_ABORT_EN
  typedef enum logic [2:0] {IDLE, SYNC, TX_DATA, STUFF, EOP1, EOP2, EOP_J, ABORT} state_t;
`else
  typedef enum logic [2:0] {IDLE, SYNC, TX_DATA, STUFF, EOP1, EOP2, EOP_J} state_t;
`endif

  // *_q registers describe the bit currently on the line; *_d is the next bit time
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] ones_q, ones_d;
  logic [7:0] data_q, data_d;
  logic       level_q, level_d;
  logic       se0_q, se0_d;
  logic       oe_q, oe_d;
  logic       ready_c;
  logic       drive;
  logic       raw;
  logic       boundary;
  logic [2:0] bit_nxt;

  assign bit_nxt = bit_cnt_q + 3'd1;

  // Next bit-time decision; nothing moves unless clk_en marks a bit boundary
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    ones_d    = ones_q;
    data_d    = data_q;
    level_d   = level_q;
    se0_d     = se0_q;
    oe_d      = oe_q;
    ready_c   = 1'b0;
    drive     = 1'b0;
    raw       = 1'b0;
    boundary  = 1'b0;
    if (clk_en) begin
      unique case (state_q)
        IDLE: begin
          if (tx_valid) begin
            ready_c   = 1'b1;
            data_d    = tx_data;
            state_d   = SYNC;
            bit_cnt_d = 3'd0;
            oe_d      = 1'b1;
            drive     = 1'b1;
            raw       = 1'b0;
          end
        end
        SYNC: begin
`ifdef USB_TX_ABORT_EN
          if (tx_abort) begin
            state_d   = ABORT;
            bit_cnt_d = 3'd0;
          end else
`endif
          if (bit_cnt_q == 3'd7) begin
            state_d   = TX_DATA;
            bit_cnt_d = 3'd0;
            drive     = 1'b1;
            raw       = data_q[0];
          end else begin
            bit_cnt_d = bit_nxt;
            drive     = 1'b1;
            raw       = (bit_nxt == 3'd7);
          end
        end
        TX_DATA: begin
`ifdef USB_TX_ABORT_EN
          if (tx_abort) begin
            state_d   = ABORT;
            bit_cnt_d = 3'd0;
          end else
`endif
          if (ones_q == 3'd6) begin
            state_d = STUFF;
            drive   = 1'b1;
            raw     = 1'b0;
          end else if (bit_cnt_q == 3'd7) begin
            boundary = 1'b1;
          end else begin
            bit_cnt_d = bit_nxt;
            drive     = 1'b1;
            raw       = data_q[bit_nxt];
          end
        end
        STUFF: begin
          if (bit_cnt_q == 3'd7) begin
            boundary = 1'b1;
          end else begin
            state_d   = TX_DATA;
            bit_cnt_d = bit_nxt;
            drive     = 1'b1;
            raw       = data_q[bit_nxt];
          end
        end
        EOP1: state_d = EOP2;
        EOP2: begin
          state_d = EOP_J;
          se0_d   = 1'b0;
          level_d = 1'b0;
        end
        EOP_J: begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
`ifdef USB_TX_ABORT_EN
        ABORT: begin
          // line level is simply held: seven raw ones with no stuff bit
          if (bit_cnt_q == 3'd6) begin
            state_d = EOP1;
            se0_d   = 1'b1;
          end else begin
            bit_cnt_d = bit_nxt;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          oe_d    = 1'b0;
          se0_d   = 1'b0;
          level_d = 1'b0;
        end
      endcase
      if (boundary) begin
        if (tx_valid) begin
          ready_c   = 1'b1;
          data_d    = tx_data;
          state_d   = TX_DATA;
          bit_cnt_d = 3'd0;
          drive     = 1'b1;
          raw       = tx_data[0];
        end else begin
          state_d = EOP1;
          se0_d   = 1'b1;
        end
      end
      // NRZI: a raw 0 toggles the line, a raw 1 holds it and extends the ones run
      if (drive) begin
        level_d = raw ? level_q : ~level_q;
        ones_d  = raw ? ones_q + 3'd1 : 3'd0;
      end
    end
  end

  // State and line registers; reset drops the line to idle J at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      ones_q    <= 3'd0;
      data_q    <= 8'd0;
      level_q   <= 1'b0;
      se0_q     <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ones_q    <= ones_d;
      data_q    <= data_d;
      level_q   <= level_d;
      se0_q     <= se0_d;
      oe_q      <= oe_d;
    end
  end

  assign tx_ready = ready_c & reset_n;
  assign d_o      = level_q;
  assign se0      = se0_q;
  assign oe       = oe_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_usb_tx.sv
// tb/tb_usb_tx.sv - randomized self-checking bench for usb_tx against a bit-time line model
module tb_usb_tx;
  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       clk_en   = 1'b0;
  logic [7:0] tx_data  = 8'd0;
  logic       tx_valid = 1'b0;
`ifdef USB_TX_ABORT_EN
  logic       tx_abort = 1'b0;
`endif
  logic       tx_ready, d_o, se0, oe, busy;

  usb_tx dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_en   (clk_en),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
`ifdef USB_TX_ABORT_EN
    .tx_abort (tx_abort),
`endif
    .tx_ready (tx_ready),
    .d_o      (d_o),
    .se0      (se0),
    .oe       (oe),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // bit-time strobe: one clk_en every en_period clocks, changed just after posedge
  int en_period = 1;
  int en_cnt    = 0;
  initial forever begin
    @(posedge clk);
    #1;
    en_cnt = (en_cnt + 1 >= en_period) ? 0 : en_cnt + 1;
    clk_en = (en_cnt == 0);
  end

  // one record per bit time (the line value during the bit that ends at the next clk_en edge)
  logic rec_on   = 1'b0;
  logic align_on = 1'b0;
  logic prev_en  = 1'b0;
  logic [3:0] prev_out = 4'd0;
  int bad_ready = 0;
  int bad_align = 0;
  int rec_oe[$], rec_se0[$], rec_d[$], rec_rdy[$];
  int exp_oe[$], exp_se0[$], exp_d[$], exp_rdy[$];

  always @(negedge clk) begin
    if (rec_on && clk_en) begin
      rec_oe.push_back(int'(oe));
      rec_se0.push_back(int'(se0));
      rec_d.push_back(int'(d_o));
      rec_rdy.push_back(int'(tx_ready));
    end
    if (tx_ready && !clk_en) bad_ready++;
    if (align_on && !prev_en && ({d_o, se0, oe, busy} != prev_out)) bad_align++;
    prev_en  = clk_en;
    prev_out = {d_o, se0, oe, busy};
  end

  // reference model: raw bit stream -> stuffing by counting ones -> NRZI levels
  logic [7:0] pkt_bytes[$];
  int         pkt_len[$];
  logic       m_level;
  int         m_ones;

  task automatic push_exp(input int o, input int s, input int d, input int r);
    exp_oe.push_back(o);
    exp_se0.push_back(s);
    exp_d.push_back(d);
    exp_rdy.push_back(r);
  endtask

  task automatic emit(input logic rawbit);
    if (!rawbit) m_level = ~m_level;
    push_exp(1, 0, int'(m_level), 0);
    m_ones = rawbit ? m_ones + 1 : 0;
    if (m_ones == 6) begin
      m_level = ~m_level;
      push_exp(1, 0, int'(m_level), 0);
      m_ones = 0;
    end
  endtask

  task automatic build_expected();
    int k;
    logic [7:0] v;
    k = 0;
    exp_oe.delete(); exp_se0.delete(); exp_d.delete(); exp_rdy.delete();
    push_exp(0, 0, 0, 1);
    foreach (pkt_len[p]) begin
      m_level = 1'b0;
      m_ones  = 0;
      for (int i = 0; i < 8; i++) emit(i == 7);
      for (int b = 0; b < pkt_len[p]; b++) begin
        v = pkt_bytes[k];
        k++;
        for (int j = 0; j < 8; j++) emit(v[j]);
        if (b < pkt_len[p] - 1) exp_rdy[exp_rdy.size() - 1] = 1;
      end
      push_exp(1, 1, 0, 0);
      push_exp(1, 1, 0, 0);
      push_exp(1, 0, 0, 0);
      push_exp(0, 0, 0, (p < pkt_len.size() - 1) ? 1 : 0);
    end
  endtask

  task automatic clear_records();
    rec_oe.delete(); rec_se0.delete(); rec_d.delete(); rec_rdy.delete();
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      if (tx_ready) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk);
      #2;
    end else check("ready_timeout", int'(ok), 1);
  endtask

  task automatic collect(input string tag);
    int c;
    c = 0;
    while (rec_oe.size() < exp_oe.size() && c < 5000) begin
      @(posedge clk);
      c++;
    end
    #2;
    rec_on = 1'b0;
    check({tag, "_len"}, rec_oe.size(), exp_oe.size());
    for (int i = 0; i < exp_oe.size() && i < rec_oe.size(); i++) begin
      check($sformatf("%s_oe[%0d]", tag, i), rec_oe[i], exp_oe[i]);
      check($sformatf("%s_se0[%0d]", tag, i), rec_se0[i], exp_se0[i]);
      check($sformatf("%s_rdy[%0d]", tag, i), rec_rdy[i], exp_rdy[i]);
      if (exp_se0[i] == 0) check($sformatf("%s_d[%0d]", tag, i), rec_d[i], exp_d[i]);
    end
  endtask

  task automatic run_packets(input string tag, input int period);
    int k;
    bit ok;
    bit seen;
    k = 0;
    en_period = period;
    build_expected();
    clear_records();
    @(posedge clk);
    #2;
    rec_on = 1'b1;
    foreach (pkt_len[p]) begin
      for (int b = 0; b < pkt_len[p]; b++) begin
        tx_data  = pkt_bytes[k];
        tx_valid = 1'b1;
        wait_ready(ok);
        k++;
      end
      tx_valid = 1'b0;
      if (p < pkt_len.size() - 1) begin
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
          @(negedge clk);
          if (se0) seen = 1'b1;
        end
        if (!seen) check("se0_timeout", int'(seen), 1);
        @(posedge clk);
        #2;
      end
    end
    collect(tag);
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 4))
      0:       return 8'hFF;
      1:       return 8'hFC;
      2:       return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic int count_q(input int which);
    int n;
    n = 0;
    for (int i = 0; i < rec_oe.size(); i++) begin
      if (which == 0 && rec_oe[i] == 1) n++;
      if (which == 1 && rec_rdy[i] == 1) n++;
    end
    return n;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dv;
    int nd;
    int np;
    bit ok;
    repeat (4) @(posedge clk);
    #2;
    check("rst_oe", int'(oe), 0);
    check("rst_se0", int'(se0), 0);
    check("rst_d", int'(d_o), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(tx_ready), 0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    align_on = 1'b1;

    // single PID A5
    pkt_bytes = '{8'hA5};
    pkt_len   = '{1};
    run_packets("t1", 1);
    check("t1_oe_bits", count_q(0), 19);
    check("t1_ready", count_q(1), 1);
    dv = 0;
    nd = 0;
    for (int i = 0; i < rec_oe.size(); i++)
      if (rec_oe[i] == 1 && rec_se0[i] == 0 && nd < 16) begin
        dv = (dv << 1) | rec_d[i];
        nd++;
      end
    check("t1_line", dv, 'hAB93);

    // stuffing inside 0xFF
    pkt_bytes = '{8'hFF, 8'h00};
    pkt_len   = '{2};
    run_packets("t2", 1);
    check("t2_oe_bits", count_q(0), 28);
    check("t2_ready", count_q(1), 2);

    // low-speed strobe, random bytes including stuff after bit 7
    pkt_bytes = '{8'hFC, rand_byte(), rand_byte()};
    pkt_len   = '{3};
    run_packets("t3", 8);

    // tx_valid raised during EOP for a second packet
    pkt_bytes = '{8'hC3, 8'h12, 8'h34};
    pkt_len   = '{1, 2};
    run_packets("t6", 3);

    for (int r = 0; r < 6; r++) begin
      pkt_bytes.delete();
      pkt_len.delete();
      np = $urandom_range(1, 2);
      for (int p = 0; p < np; p++) begin
        pkt_len.push_back($urandom_range(1, 4));
        for (int b = 0; b < pkt_len[p]; b++) pkt_bytes.push_back(rand_byte());
      end
      run_packets($sformatf("rnd%0d", r), $urandom_range(1, 8));
    end

    // reset in the middle of byte 2
    en_period = 2;
    align_on  = 1'b0;
    @(posedge clk);
    #2;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    wait_ready(ok);
    tx_data = 8'h96;
    wait_ready(ok);
    tx_data = 8'h11;
    repeat (6) @(posedge clk);
    #3;
    check("t4_busy_pre", int'(busy), 1);
    check("t4_oe_pre", int'(oe), 1);
    reset_n = 1'b0;
    #1;
    check("t4_oe", int'(oe), 0);
    check("t4_se0", int'(se0), 0);
    check("t4_d", int'(d_o), 0);
    check("t4_busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_ready_in_reset", int'(tx_ready), 0);
    end
    tx_valid = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    check("t4_idle_after", int'(busy), 0);
    align_on = 1'b1;
    pkt_bytes = '{rand_byte(), rand_byte()};
    pkt_len   = '{2};
    run_packets("t4_restart", 2);

`ifdef USB_TX_ABORT_EN
    // abort during the fourth data bit of 0x00
    pkt_bytes = '{8'h00, 8'h55};
    pkt_len   = '{2};
    en_period = 1;
    build_expected();
    while (exp_oe.size() > 13) begin
      void'(exp_oe.pop_back()); void'(exp_se0.pop_back());
      void'(exp_d.pop_back()); void'(exp_rdy.pop_back());
    end
    dv = exp_d[12];
    for (int i = 0; i < 7; i++) push_exp(1, 0, dv, 0);
    push_exp(1, 1, 0, 0);
    push_exp(1, 1, 0, 0);
    push_exp(1, 0, 0, 0);
    push_exp(0, 0, 0, 0);
    clear_records();
    @(posedge clk);
    #2;
    rec_on   = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    wait_ready(ok);
    tx_data = 8'h55;
    for (int c = 0; c < 200 && rec_oe.size() < 12; c++) @(posedge clk);
    #2;
    tx_abort = 1'b1;
    @(posedge clk);
    #2;
    tx_abort = 1'b0;
    tx_valid = 1'b0;
    collect("t5");
    check("t5_ready", count_q(1), 1);
`endif

    repeat (4) @(posedge clk);
    check("ready_outside_clk_en", bad_ready, 0);
    check("line_change_off_strobe", bad_align, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
